// File: rtl/subtractor_serial_n_pkg.sv
// -----------------------------------------------------------------------------
// subtractor_pkg
// Shared types and helpers for the bit-serial subtractor.
//   state_t    : control FSM states (S_IDLE, S_BUSY, S_DONE)
//   cnt_width  : bit-position counter width, $clog2(n)+1, so that counting
//                0..n-1 never wraps inside one operation.
// Optional feature macro used by this slice: SUBTRACTOR_ADD_MODE_EN.
// -----------------------------------------------------------------------------
package subtractor_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/subtractor_serial_n_if.sv
// -----------------------------------------------------------------------------
// subtractor_serial_n_if
// Operand / result handshake bundle for subtractor_serial_n.
//   i_valid, a, b, b_in (and add when SUBTRACTOR_ADD_MODE_EN) : operand side
//   o_ready                                                    : operand accept
//   o_valid, diff, b_out, overflow                             : result side
//   i_ready                                                    : result accept
// modport slave  : the subtractor
// modport master : the producer/consumer driving it
// -----------------------------------------------------------------------------
interface subtractor_serial_n_if #(
    parameter int N = 8
);
`ifdef SUBTRACTOR_ADD_MODE_EN
    logic         add;
`endif
    logic         i_valid;
    logic         o_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         b_in;
    logic         o_valid;
    logic         i_ready;
    logic [N-1:0] diff;
    logic         b_out;
    logic         overflow;

    modport slave (
`ifdef SUBTRACTOR_ADD_MODE_EN
        input  add,
`endif
        input  i_valid, a, b, b_in, i_ready,
        output o_ready, o_valid, diff, b_out, overflow
    );

    modport master (
`ifdef SUBTRACTOR_ADD_MODE_EN
        output add,
`endif
        output i_valid, a, b, b_in, i_ready,
        input  o_ready, o_valid, diff, b_out, overflow
    );
endinterface

// File: rtl/subtractor_serial_n_full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// One-bit combinational subtract cell: d = a ^ b ^ bin,
// bo = (~a & b) | (~(a ^ b) & bin).
//   a, b, bin : operand bits and borrow in
//   add       : (SUBTRACTOR_ADD_MODE_EN only) 1 = add; bin/bo then carry
//   d, bo     : difference (or sum) bit and borrow (or carry) out
// In add mode b and the carry sense are inverted around the same borrow
// equations: a - ~b - ~cin = a + b + cin - 2^N, and borrow = ~carry.
// -----------------------------------------------------------------------------
module full_subtractor (
`ifdef SUBTRACTOR_ADD_MODE_EN
    input  logic add,
`endif
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);
    logic w_b;
    logic w_bin;
    logic w_bo;

`ifdef SUBTRACTOR_ADD_MODE_EN
    assign w_b   = b ^ add;
    assign w_bin = bin ^ add;
    assign bo    = w_bo ^ add;
`else
    assign w_b   = b;
    assign w_bin = bin;
    assign bo    = w_bo;
`endif

    assign d    = a ^ w_b ^ w_bin;
    assign w_bo = (~a & w_b) | (~(a ^ w_b) & w_bin);
endmodule

// File: rtl/subtractor_serial_n.sv
// -----------------------------------------------------------------------------
// subtractor_serial_n
// Bit-serial N-bit subtractor: (a - b - b_in) mod 2^N, one bit per clock,
// LSB first. Result ready exactly N edges after the operand accept edge.
//   clk, rst_n : clock, asynchronous active-low reset (aborts any operation)
//   bus        : subtractor_serial_n_if.slave (operand and result handshakes)
// Optional macro SUBTRACTOR_ADD_MODE_EN adds bus.add (sampled at accept)
// selecting a + b + b_in with carry out on b_out.
// -----------------------------------------------------------------------------
module subtractor_serial_n
    import subtractor_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    subtractor_serial_n_if.slave  bus
);
    localparam int CW = cnt_width(N);
    localparam int IW = $clog2(N);

    state_t         r_state;
    state_t         w_state_next;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [N-1:0]   r_diff;
    logic           r_borrow;
    logic           r_b_out;
    logic           r_overflow;
    logic [CW-1:0]  r_count;
    logic           w_last;
    logic           w_d;
    logic           w_bo;
`ifdef SUBTRACTOR_ADD_MODE_EN
    logic           r_add;
`endif

    assign w_last = (r_count == CW'(N - 1));

    full_subtractor u_cell (
`ifdef SUBTRACTOR_ADD_MODE_EN
        .add (r_add),
`endif
        .a   (r_a[r_count[IW-1:0]]),
        .b   (r_b[r_count[IW-1:0]]),
        .bin (r_borrow),
        .d   (w_d),
        .bo  (w_bo)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.i_valid) begin
                    w_state_next = S_BUSY;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_BUSY: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_BUSY;
                end
            end
            S_DONE: begin
                if (bus.i_ready) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, serial shift, result/flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_diff     <= '0;
            r_borrow   <= 1'b0;
            r_b_out    <= 1'b0;
            r_overflow <= 1'b0;
            r_count    <= '0;
`ifdef SUBTRACTOR_ADD_MODE_EN
            r_add      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_valid) begin
                        r_a      <= bus.a;
                        r_b      <= bus.b;
                        r_borrow <= bus.b_in;
                        r_count  <= '0;
`ifdef SUBTRACTOR_ADD_MODE_EN
                        r_add    <= bus.add;
`endif
                    end
                end
                S_BUSY: begin
                    r_diff   <= {w_d, r_diff[N-1:1]};
                    r_borrow <= w_bo;
                    r_count  <= r_count + CW'(1);
                    // r_borrow here is the borrow into the MSB cell, so the
                    // signed-overflow flag is formed on this same edge.
                    if (w_last) begin
                        r_b_out    <= w_bo;
                        r_overflow <= r_borrow ^ w_bo;
                    end
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

    assign bus.o_ready  = (r_state == S_IDLE);
    assign bus.o_valid  = (r_state == S_DONE);
    assign bus.diff     = r_diff;
    assign bus.b_out    = r_b_out;
    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_subtractor_serial_n.sv
module tb_subtractor_serial_n;
    localparam int N = 8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] ed;
        logic       ebo;
        logic       eov;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic busy_ok;

    subtractor_serial_n_if #(.N(N)) bus ();

    subtractor_serial_n #(.N(N)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One full transaction: accept, wait for result, optional backpressure, handshake.
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vbin,
                          input int rdelay, output logic [7:0] rd, output logic rbo,
                          output logic rov, output int lat);
        int g;
        @(negedge clk);
        bus.a = va; bus.b = vb; bus.b_in = vbin; bus.i_valid = 1'b1;
        g = 0;
        while (!bus.o_ready && g < 30) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.a = ~va; bus.b = ~vb; bus.b_in = ~vbin;
        lat = 0;
        busy_ok = 1'b1;
        while (!bus.o_valid && lat < 30) begin
            if (bus.o_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        rd = bus.diff; rbo = bus.b_out; rov = bus.overflow;
        repeat (rdelay) @(posedge clk);
        @(negedge clk);
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_hs_valid", {15'd0, bus.o_valid}, 16'd0);
        chk("post_hs_ready", {15'd0, bus.o_ready}, 16'd1);
        bus.i_ready = 1'b0;
    endtask

    initial begin
        vec_t       vecs[7];
        logic [7:0] rd;
        logic       rbo;
        logic       rov;
        int         lat;
        logic [8:0] ref9;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbin;
        logic [7:0] rdref;
        logic       rov_ref;

        total = 0;
        bad   = 0;
        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
        vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        rst_n = 1'b0;
        bus.i_valid = 1'b0; bus.i_ready = 1'b0;
        bus.a = 8'h00; bus.b = 8'h00; bus.b_in = 1'b0;
`ifdef SUBTRACTOR_ADD_MODE_EN
        bus.add = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", {15'd0, bus.o_ready}, 16'd1);
        chk("rst_valid", {15'd0, bus.o_valid}, 16'd0);
        chk("rst_diff", {8'd0, bus.diff}, 16'd0);
        chk("rst_bout", {15'd0, bus.b_out}, 16'd0);
        chk("rst_ovf", {15'd0, bus.overflow}, 16'd0);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, i % 3, rd, rbo, rov, lat);
            chk("vec_latency", lat[15:0], 16'd8);
            chk("vec_busy_ready", {15'd0, busy_ok}, 16'd1);
            chk("vec_diff", {8'd0, rd}, {8'd0, vecs[i].ed});
            chk("vec_bout", {15'd0, rbo}, {15'd0, vecs[i].ebo});
            chk("vec_ovf", {15'd0, rov}, {15'd0, vecs[i].eov});
        end

        // Backpressure with new operands offered during S_DONE
        @(negedge clk);
        bus.a = 8'h33; bus.b = 8'h11; bus.b_in = 1'b0; bus.i_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        lat = 0;
        while (!bus.o_valid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp_latency", lat[15:0], 16'd8);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.i_valid = 1'b1;
            bus.a = 8'($urandom); bus.b = 8'($urandom); bus.b_in = 1'($urandom);
            @(posedge clk);
            #1;
            chk("bp_diff_held", {8'd0, bus.diff}, 16'h0022);
            chk("bp_ready_low", {15'd0, bus.o_ready}, 16'd0);
            chk("bp_valid_high", {15'd0, bus.o_valid}, 16'd1);
        end
        @(negedge clk);
        bus.i_valid = 1'b0; bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_hs_ready", {15'd0, bus.o_ready}, 16'd1);
        chk("bp_hs_valid", {15'd0, bus.o_valid}, 16'd0);
        bus.i_ready = 1'b0;

        // Reset in the middle of S_BUSY (count = 3)
        @(negedge clk);
        bus.a = 8'h44; bus.b = 8'h04; bus.b_in = 1'b0; bus.i_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {15'd0, bus.o_valid}, 16'd0);
        chk("mid_rst_ready", {15'd0, bus.o_ready}, 16'd1);
        chk("mid_rst_diff", {8'd0, bus.diff}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h44, 8'h04, 1'b0, 0, rd, rbo, rov, lat);
        chk("after_rst_latency", lat[15:0], 16'd8);
        chk("after_rst_diff", {8'd0, rd}, 16'h0040);
        chk("after_rst_bout", {15'd0, rbo}, 16'd0);

        // Random operations against a 9-bit reference
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(ra, rb, rbin, int'($urandom_range(0, 3)), rd, rbo, rov, lat);
            ref9    = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
            rdref   = ref9[7:0];
            rov_ref = (ra[7] != rb[7]) && (rdref[7] != ra[7]);
            chk("rnd_latency", lat[15:0], 16'd8);
            chk("rnd_diff", {8'd0, rd}, {8'd0, rdref});
            chk("rnd_bout", {15'd0, rbo}, {15'd0, ref9[8]});
            chk("rnd_ovf", {15'd0, rov}, {15'd0, rov_ref});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
